// File: rtl/imem_rsp_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Address checks live here so the loader and fetch paths agree on them.
package imem_rsp_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [31:0] NOP     = 32'h0000_0033;
    localparam int          LAT_MIN = 1;
    localparam int          LAT_MAX = 15;
    localparam int          CNT_W   = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    // Offset is unsigned, so an address below base wraps high and fails the range test.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned depth);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || ({1'b0, off} >= (33'(depth) << 2));
    endfunction

    function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/imem_rsp_if.sv
// Fetch-side request/response bus plus the program-loader write port.
interface imem_rsp_if;
    logic        i_req_vld;
    logic        o_req_rdy;
    logic [31:0] i_req_addr;
    logic        o_rsp_vld;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        i_flush;
    logic        i_ld_we;
    logic [31:0] i_ld_addr;
    logic [31:0] i_ld_wdata;

    modport master (
        output i_req_vld, i_req_addr, i_flush, i_ld_we, i_ld_addr, i_ld_wdata,
        input  o_req_rdy, o_rsp_vld, o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_vld, i_req_addr, i_flush, i_ld_we, i_ld_addr, i_ld_wdata,
        output o_req_rdy, o_rsp_vld, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/imem_rsp_array.sv
// DEPTH x 32 word storage: synchronous write, registered read.
// A same-edge write to the read word is forwarded so the read sees it.
module imem_array #(
    parameter  int DEPTH = 1024,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [IW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        o_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : mem[i_raddr];
    end

endmodule

// File: rtl/imem_rsp.sv
// Fixed-latency instruction responder: accepts one fetch at a time, answers
// LATENCY cycles later with the stored word or an error NOP, flushable.
module imem_rsp
    import imem_rsp_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    imem_rsp_if.slave    bus
);

    localparam int IW  = $clog2(DEPTH);
    // Out-of-range latencies saturate to the supported window.
    localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                         (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      addr_q;
    logic [31:0]      arr_rdata;
    logic [IW-1:0]    rd_idx, ld_idx;
    logic             accept, ld_ok, rsp_err, rsp_vld;
    rsp_t             rsp_q, rsp_now, rsp_out;

    assign bus.o_req_rdy = (state == ST_IDLE) && i_rst_n;
    assign accept        = bus.i_req_vld && bus.o_req_rdy && !bus.i_flush;

    // The word is read on the edge entering RESP: from the live address when
    // LATENCY is 1, otherwise from the captured one.
    assign rd_idx = IW'(word_off((state == ST_IDLE) ? bus.i_req_addr : addr_q, BASE_ADDR));
    assign ld_idx = IW'(word_off(bus.i_ld_addr, BASE_ADDR));
    assign ld_ok  = bus.i_ld_we && !addr_bad(bus.i_ld_addr, BASE_ADDR, DEPTH);

    imem_array #(.DEPTH(DEPTH)) u_array (
        .i_clk   (i_clk),
        .i_we    (ld_ok),
        .i_waddr (ld_idx),
        .i_wdata (bus.i_ld_wdata),
        .i_raddr (rd_idx),
        .o_rdata (arr_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            rsp_q  <= '{rdata: NOP, err: 1'b0};
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept)  addr_q <= bus.i_req_addr;
            if (rsp_vld) rsp_q  <= rsp_now;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: if (accept) begin
                cnt_n   = CNT_W'(LAT - 1);
                state_n = (LAT == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: if (bus.i_flush) begin
                state_n = ST_IDLE;
            end else begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_n = ST_RESP;
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign rsp_err = addr_bad(addr_q, BASE_ADDR, DEPTH);
    assign rsp_vld = (state == ST_RESP) && !bus.i_flush;
    assign rsp_now = '{rdata: rsp_err ? NOP : arr_rdata, err: rsp_err};
    assign rsp_out = rsp_vld ? rsp_now : rsp_q;

    assign bus.o_rsp_vld   = rsp_vld;
    assign bus.o_rsp_rdata = rsp_out.rdata;
    assign bus.o_rsp_err   = rsp_out.err;

endmodule

// File: tb/tb_imem_rsp.sv
// Three responders (different latency/base) share one stimulus stream and are
// compared every cycle against a due-cycle reference model.
module tb_imem_rsp;
    import imem_rsp_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_vld = 1'b0, flush = 1'b0, ld_we = 1'b0;
    logic [31:0] req_addr = '0, ld_addr = '0, ld_wdata = '0;
    logic        rdy_o [3], vld_o [3], er_o [3];
    logic [31:0] rd_o [3];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        imem_rsp_if bus();
        assign bus.i_req_vld  = req_vld;
        assign bus.i_req_addr = req_addr;
        assign bus.i_flush    = flush;
        assign bus.i_ld_we    = ld_we;
        assign bus.i_ld_addr  = ld_addr;
        assign bus.i_ld_wdata = ld_wdata;
        imem_rsp #(
            .DEPTH     (DEPTH),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 4 : 3)),
            .BASE_ADDR ((g == 2) ? 32'h0000_1000 : 32'h0000_0000)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus)
        );
        assign rdy_o[g] = bus.o_req_rdy;
        assign vld_o[g] = bus.o_rsp_vld;
        assign rd_o[g]  = bus.o_rsp_rdata;
        assign er_o[g]  = bus.o_rsp_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 3);
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic bit m_err(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_of(k);
        return (a[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
    endfunction

    function automatic int m_idx(input int k, input logic [31:0] a);
        return int'((a - base_of(k)) >> 2) % DEPTH;
    endfunction

    // Reference: a request accepted in cycle c is due in cycle c+LATENCY and
    // returns memory as it stands at the start of that cycle.
    logic [31:0] mem [3][DEPTH];
    bit          pend [3];
    longint      due [3];
    logic [31:0] paddr [3], hold_d [3];
    logic        hold_e [3];
    longint      cyc = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit e_rdy, e_vld;
            e_rdy = 1'b0;
            e_vld = 1'b0;
            if (!rst_n) begin
                pend[k]   = 1'b0;
                hold_d[k] = NOP;
                hold_e[k] = 1'b0;
            end else begin
                e_rdy = !pend[k];
                e_vld = pend[k] && (cyc == due[k]) && !flush;
                if (e_vld) begin
                    hold_e[k] = m_err(k, paddr[k]);
                    hold_d[k] = hold_e[k] ? NOP : mem[k][m_idx(k, paddr[k])];
                end
            end
            chk($sformatf("u%0d rdy c%0d", k, cyc), rdy_o[k], e_rdy);
            chk($sformatf("u%0d vld c%0d", k, cyc), vld_o[k], e_vld);
            chk($sformatf("u%0d rdata c%0d", k, cyc), rd_o[k], hold_d[k]);
            chk($sformatf("u%0d err c%0d", k, cyc), er_o[k], hold_e[k]);
            if (rst_n) begin
                if (pend[k] && (flush || cyc == due[k])) begin
                    pend[k] = 1'b0;
                end else if (!pend[k] && req_vld && !flush) begin
                    pend[k]  = 1'b1;
                    due[k]   = cyc + lat_of(k);
                    paddr[k] = req_addr;
                end
            end
        end
        if (ld_we)
            for (int k = 0; k < 3; k++)
                if (!m_err(k, ld_addr)) mem[k][m_idx(k, ld_addr)] = ld_wdata;
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        flush   = 1'b0;
        ld_we   = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_we    = 1'b1;
        ld_addr  = a;
        ld_wdata = d;
        nxt();
    endtask

    task automatic req(input logic [31:0] a);
        req_vld  = 1'b1;
        req_addr = a;
        nxt();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] w;
        w = 32'($urandom_range(0, DEPTH - 1)) << 2;
        case ($urandom_range(0, 6))
            0, 1:    return w;
            2, 3:    return 32'h0000_1000 + w;
            4:       return w | 32'($urandom_range(1, 3));
            5:       return ($urandom_range(0, 1) != 0) ? 32'(DEPTH * 4) : 32'h0000_1000 + 32'(DEPTH * 4);
            default: return ($urandom_range(0, 1) != 0) ? 32'h0000_0FFC : 32'($urandom);
        endcase
    endfunction

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst rdy", rdy_o[0], 1'b0);
        chk("rst rdata", rd_o[1], NOP);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            load(32'(i * 4), $urandom);
            load(32'h0000_1000 + 32'(i * 4), $urandom);
        end
        repeat (6) nxt();

        // Basic read at latency 1
        load(32'h10, 32'hDEADBEEF);
        req(32'h10);
        #1;
        chk("032 vld", vld_o[0], 1'b1);
        chk("032 rdata", rd_o[0], 32'hDEADBEEF);
        chk("032 err", er_o[0], 1'b0);
        repeat (5) nxt();

        // Latency 4 timing of ready and valid
        req(32'h0);
        for (int j = 1; j <= 4; j++) begin
            #1;
            chk($sformatf("033 rdy c%0d", j), rdy_o[1], 1'b0);
            chk($sformatf("033 vld c%0d", j), vld_o[1], (j == 4) ? 1'b1 : 1'b0);
            nxt();
        end
        #1;
        chk("033 rdy c5", rdy_o[1], 1'b1);
        nxt();

        // Misaligned and just-past-end requests
        req(32'h6);
        #1;
        chk("034 mis err", er_o[0], 1'b1);
        chk("034 mis rdata", rd_o[0], NOP);
        repeat (5) nxt();
        req(32'(DEPTH * 4));
        #1;
        chk("034 oor err", er_o[0], 1'b1);
        repeat (5) nxt();

        // Flush two cycles after accept kills the latency-3 response
        req(32'h0000_1000);
        nxt();
        flush = 1'b1;
        nxt();
        cnt = 0;
        repeat (5) begin
            #1;
            cnt += int'(vld_o[2]);
            nxt();
        end
        chk("035 no rsp", 32'(cnt), 32'd0);
        req(32'h0000_1004);
        nxt();
        nxt();
        #1;
        chk("035 vld", vld_o[2], 1'b1);
        chk("035 rdata", rd_o[2], mem[2][1]);
        repeat (3) nxt();

        // Loader write during the response cycle
        load(32'h20, 32'h22222222);
        req(32'h20);
        #1;
        chk("036 old", rd_o[0], 32'h22222222);
        load(32'h20, 32'h11111111);
        repeat (5) nxt();
        req(32'h20);
        #1;
        chk("036 new", rd_o[0], 32'h11111111);
        repeat (5) nxt();

        // Reset in the middle of a wait
        req(32'h0000_1008);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("037 rdy", rdy_o[1], 1'b0);
        chk("037 vld", vld_o[1], 1'b0);
        chk("037 rdata", rd_o[1], NOP);
        chk("037 err", er_o[2], 1'b0);
        nxt();
        nxt();
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            nxt();
            #1;
            cnt += int'(vld_o[1]) + int'(vld_o[2]);
        end
        chk("037 no rsp", 32'(cnt), 32'd0);

        for (int i = 0; i < 800; i++) begin
            req_vld  = ($urandom_range(0, 1) != 0);
            req_addr = rnd_addr();
            flush    = ($urandom_range(0, 7) == 0);
            ld_we    = ($urandom_range(0, 3) == 0);
            ld_addr  = rnd_addr();
            ld_wdata = $urandom;
            nxt();
        end
        repeat (8) nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
